// File: rtl/ft245_fifo_bridge_pkg.sv
// Shared types for the FT245 FIFO bridge: FSM state encodings, byte type and
// default FIFO address widths.
package ft245_fifo_bridge_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned RX_AW_DEFAULT = 3;
  localparam int unsigned TX_AW_DEFAULT = 3;

  typedef logic [DATA_W-1:0] byte_t;

  typedef enum logic {
    RX_IDLE = 1'b0,
    RX_ACK  = 1'b1
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_REQ  = 2'd1,
    TX_WAIT = 2'd2
  } tx_state_e;

endpackage

// File: rtl/ft245_fifo_bridge_if.sv
// Bundle of the FT245 state-machine handshake and the user-side FIFO ports.
// The bridge takes the master view; the SM/user environment takes the slave view.
interface ft245_fifo_bridge_if;
  import ft245_fifo_bridge_pkg::*;

  logic  DATA_BYTE_READY;
  byte_t RX_BYTE;
  logic  RSB_INT_EN;
  logic  ENDPOINT_BUSY;
  logic  FT_245_SM_BUSY;
  logic  WRITE_EN;
  logic  WRITE_READY;
  byte_t WRITE_BYTE;
  logic  WRITE_COMPLETE;
  byte_t RX_DATA;
  logic  RX_VALID;
  logic  RX_POP;
  byte_t TX_DATA;
  logic  TX_PUSH;
  logic  TX_FULL;
  logic  RX_OVERFLOW;

  modport master (
    input  DATA_BYTE_READY, RX_BYTE, FT_245_SM_BUSY, WRITE_READY, WRITE_COMPLETE,
           RX_POP, TX_DATA, TX_PUSH,
    output RSB_INT_EN, ENDPOINT_BUSY, WRITE_EN, WRITE_BYTE, RX_DATA, RX_VALID,
           TX_FULL, RX_OVERFLOW
  );

  modport slave (
    output DATA_BYTE_READY, RX_BYTE, FT_245_SM_BUSY, WRITE_READY, WRITE_COMPLETE,
           RX_POP, TX_DATA, TX_PUSH,
    input  RSB_INT_EN, ENDPOINT_BUSY, WRITE_EN, WRITE_BYTE, RX_DATA, RX_VALID,
           TX_FULL, RX_OVERFLOW
  );

endinterface

// File: rtl/ft245_sync_fifo.sv
// Single-clock byte FIFO, 2^AW entries, extra pointer bit distinguishes full
// from empty. Head is presented combinationally from storage.
module ft245_sync_fifo
  import ft245_fifo_bridge_pkg::*;
#(
  parameter int unsigned AW = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        push_i,
  input  byte_t       din_i,
  input  logic        pop_i,
  output byte_t       dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic [AW:0] count_o
);

  localparam int unsigned DEPTH = 1 << AW;

  byte_t       mem_q [DEPTH];
  logic [AW:0] wptr_q;
  logic [AW:0] rptr_q;
  logic        do_push;
  logic        do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count_o = wptr_q - rptr_q;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers define validity, and
  // a reset-free array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// Bridges the FT245 byte state machine to user logic through an RX and a TX
// FIFO, with read throttling and a sticky RX overflow flag.
module ft245_fifo_bridge
  import ft245_fifo_bridge_pkg::*;
#(
  parameter int unsigned RX_AW = RX_AW_DEFAULT,
  parameter int unsigned TX_AW = TX_AW_DEFAULT
) (
  input  logic                CLK,
  input  logic                RST_N,
  ft245_fifo_bridge_if.master bus
);

  // One slot stays free for a byte the SM may already be reading.
  localparam logic [RX_AW:0] RX_BUSY_LEVEL = (RX_AW+1)'((1 << RX_AW) - 1);

  rx_state_e      rx_state_q;
  logic           rsb_int_en_q;
  logic           rx_overflow_q;
  logic           ep_busy_q;
  logic           rx_push;
  logic           rx_full;
  logic           rx_empty;
  logic [RX_AW:0] rx_count;
  byte_t          rx_head;

  tx_state_e      tx_state_q;
  logic           write_en_q;
  byte_t          write_byte_q;
  logic           tx_pop;
  logic           tx_full;
  logic           tx_empty;
  logic [TX_AW:0] tx_count;
  byte_t          tx_head;

  assign rx_push = (rx_state_q == RX_IDLE) && bus.DATA_BYTE_READY;
  assign tx_pop  = (tx_state_q == TX_WAIT) && bus.WRITE_COMPLETE && !tx_empty;

  ft245_sync_fifo #(.AW(RX_AW)) u_rx_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (rx_push),
    .din_i   (bus.RX_BYTE),
    .pop_i   (bus.RX_POP),
    .dout_o  (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  ft245_sync_fifo #(.AW(TX_AW)) u_tx_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .push_i  (bus.TX_PUSH),
    .din_i   (bus.TX_DATA),
    .pop_i   (tx_pop),
    .dout_o  (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  // A read byte is always acknowledged, even when dropped, so the SM never stalls.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_state_q    <= RX_IDLE;
      rsb_int_en_q  <= 1'b0;
      rx_overflow_q <= 1'b0;
      ep_busy_q     <= 1'b0;
    end else begin
      ep_busy_q <= (rx_count >= RX_BUSY_LEVEL);
      case (rx_state_q)
        RX_IDLE: begin
          if (bus.DATA_BYTE_READY) begin
            rx_state_q   <= RX_ACK;
            rsb_int_en_q <= 1'b1;
            if (rx_full) rx_overflow_q <= 1'b1;
          end
        end
        RX_ACK: begin
          if (!bus.DATA_BYTE_READY) begin
            rx_state_q   <= RX_IDLE;
            rsb_int_en_q <= 1'b0;
          end
        end
        default: begin
          rx_state_q   <= RX_IDLE;
          rsb_int_en_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tx_state_q   <= TX_IDLE;
      write_en_q   <= 1'b0;
      write_byte_q <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if ((tx_count != '0) && !bus.FT_245_SM_BUSY) begin
            tx_state_q   <= TX_REQ;
            write_en_q   <= 1'b1;
            write_byte_q <= tx_head;
          end
        end
        TX_REQ: begin
          if (bus.WRITE_READY) begin
            tx_state_q <= TX_WAIT;
            write_en_q <= 1'b0;
          end
        end
        TX_WAIT: begin
          if (bus.WRITE_COMPLETE) tx_state_q <= TX_IDLE;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          write_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.RSB_INT_EN    = rsb_int_en_q;
  assign bus.ENDPOINT_BUSY = ep_busy_q;
  assign bus.RX_OVERFLOW   = rx_overflow_q;
  assign bus.WRITE_EN      = write_en_q;
  assign bus.WRITE_BYTE    = write_byte_q;
  assign bus.RX_DATA       = rx_head;
  assign bus.RX_VALID      = !rx_empty;
  assign bus.TX_FULL       = tx_full;

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// Self-checking bench for ft245_fifo_bridge: randomized bytes checked against
// queue-based models of the RX and TX FIFOs and the SM handshakes.
module tb_ft245_fifo_bridge;
  import ft245_fifo_bridge_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ft245_fifo_bridge_if bus ();

  ft245_fifo_bridge #(.RX_AW(3), .TX_AW(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int    checks = 0;
  int    failures = 0;
  byte_t rx_model[$];
  byte_t tx_model[$];
  bit    ovf_model = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One SM read: byte presented, acked next edge, DATA_BYTE_READY held `hold` extra cycles.
  task automatic rx_send(input byte_t b, input int hold);
    bus.DATA_BYTE_READY = 1'b1;
    bus.RX_BYTE = b;
    tick();
    if (rx_model.size() < DEPTH) rx_model.push_back(b);
    else ovf_model = 1'b1;
    check("rsb_set", bus.RSB_INT_EN, 1);
    check("rx_overflow", bus.RX_OVERFLOW, ovf_model);
    repeat (hold) begin
      tick();
      check("rsb_hold", bus.RSB_INT_EN, 1);
    end
    bus.DATA_BYTE_READY = 1'b0;
    bus.RX_BYTE = 8'($urandom);
    tick();
    check("rsb_clr", bus.RSB_INT_EN, 0);
  endtask

  task automatic rx_pop_one();
    check("rx_valid", bus.RX_VALID, rx_model.size() != 0);
    if (rx_model.size() != 0) check("rx_data", bus.RX_DATA, rx_model[0]);
    bus.RX_POP = 1'b1;
    tick();
    bus.RX_POP = 1'b0;
    if (rx_model.size() != 0) void'(rx_model.pop_front());
  endtask

  task automatic tx_push(input byte_t b);
    check("tx_full_pre", bus.TX_FULL, tx_model.size() == DEPTH);
    bus.TX_PUSH = 1'b1;
    bus.TX_DATA = b;
    tick();
    bus.TX_PUSH = 1'b0;
    if (tx_model.size() < DEPTH) tx_model.push_back(b);
  endtask

  task automatic wait_wen(output bit ok);
    for (int i = 0; i < 16 && !bus.WRITE_EN; i++) tick();
    ok = bus.WRITE_EN;
    if (!ok) check("wen_timeout", 0, 1);
  endtask

  // One full SM write cycle; optionally pushes a new byte on the pop edge.
  task automatic tx_drain_one(input bit refill, input byte_t rb);
    bit    ok;
    byte_t exp;
    wait_wen(ok);
    if (!ok) return;
    if (tx_model.size() == 0) begin
      check("tx_spurious_wen", 1, 0);
      return;
    end
    exp = tx_model[0];
    check("wbyte_req", bus.WRITE_BYTE, exp);
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("wen_hold", bus.WRITE_EN, 1);
      check("wbyte_hold", bus.WRITE_BYTE, exp);
    end
    bus.WRITE_READY = 1'b1;
    tick();
    bus.WRITE_READY = 1'b0;
    check("wen_in_wait", bus.WRITE_EN, 0);
    repeat ($urandom_range(0, 2)) begin
      tick();
      check("wen_wait_hold", bus.WRITE_EN, 0);
      check("wbyte_wait_hold", bus.WRITE_BYTE, exp);
    end
    bus.WRITE_COMPLETE = 1'b1;
    if (refill) begin
      bus.TX_PUSH = 1'b1;
      bus.TX_DATA = rb;
    end
    tick();
    bus.WRITE_COMPLETE = 1'b0;
    bus.TX_PUSH = 1'b0;
    void'(tx_model.pop_front());
    if (refill) tx_model.push_back(rb);
    check("wen_after_pop", bus.WRITE_EN, 0);
    check("tx_full", bus.TX_FULL, tx_model.size() == DEPTH);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit    ok;
    byte_t b;

    bus.DATA_BYTE_READY = 1'b0;
    bus.RX_BYTE = '0;
    bus.FT_245_SM_BUSY = 1'b0;
    bus.WRITE_READY = 1'b0;
    bus.WRITE_COMPLETE = 1'b0;
    bus.RX_POP = 1'b0;
    bus.TX_DATA = '0;
    bus.TX_PUSH = 1'b0;

    repeat (3) tick();
    check("rst_rsb", bus.RSB_INT_EN, 0);
    check("rst_ep_busy", bus.ENDPOINT_BUSY, 0);
    check("rst_wen", bus.WRITE_EN, 0);
    check("rst_wbyte", bus.WRITE_BYTE, 0);
    check("rst_rx_valid", bus.RX_VALID, 0);
    check("rst_tx_full", bus.TX_FULL, 0);
    check("rst_ovf", bus.RX_OVERFLOW, 0);
    rst_n = 1'b1;
    tick();

    // Single RX byte
    rx_send(8'hA5, $urandom_range(0, 3));
    check("single_rx_valid", bus.RX_VALID, 1);
    rx_pop_one();
    check("single_rx_empty", bus.RX_VALID, 0);

    // RX fill, throttle and overflow
    for (int i = 1; i <= 7; i++) begin
      rx_send(byte_t'(i), $urandom_range(0, 1));
      if (i == 6) check("ep_busy_at6", bus.ENDPOINT_BUSY, 0);
    end
    check("ep_busy_at7", bus.ENDPOINT_BUSY, 1);
    rx_send(8'h08, 0);
    check("ovf_after8", bus.RX_OVERFLOW, 0);
    rx_send(8'h09, 0);
    check("ovf_after9", bus.RX_OVERFLOW, 1);
    for (int i = 0; i < 8; i++) rx_pop_one();
    tick();
    check("ovf_sticky", bus.RX_OVERFLOW, 1);
    check("ep_busy_drained", bus.ENDPOINT_BUSY, 0);
    check("rx_empty_drained", bus.RX_VALID, 0);

    // TX burst
    tx_push(8'h10);
    tx_push(8'h11);
    tx_push(8'h12);
    for (int i = 0; i < 3; i++) tx_drain_one(1'b0, 8'h00);

    // TX full boundary, with the SM busy so nothing drains
    bus.FT_245_SM_BUSY = 1'b1;
    for (int i = 0; i < DEPTH; i++) tx_push(8'($urandom));
    check("tx_full_set", bus.TX_FULL, 1);
    tx_push(8'($urandom));
    check("tx_wen_blocked", bus.WRITE_EN, 0);
    bus.FT_245_SM_BUSY = 1'b0;
    for (int i = 0; i < DEPTH; i++) tx_drain_one(1'b0, 8'h00);
    check("tx_full_clr", bus.TX_FULL, 0);

    // Contention: SM busy blocks writes; release coincides with an RX byte
    bus.FT_245_SM_BUSY = 1'b1;
    tx_push(8'($urandom));
    tx_push(8'($urandom));
    repeat (4) begin
      tick();
      check("contention_wen", bus.WRITE_EN, 0);
    end
    b = 8'($urandom);
    bus.FT_245_SM_BUSY = 1'b0;
    bus.DATA_BYTE_READY = 1'b1;
    bus.RX_BYTE = b;
    tick();
    rx_model.push_back(b);
    check("release_wen", bus.WRITE_EN, 1);
    check("release_rsb", bus.RSB_INT_EN, 1);
    bus.DATA_BYTE_READY = 1'b0;
    tick();
    check("release_rsb_clr", bus.RSB_INT_EN, 0);
    tx_drain_one(1'b0, 8'h00);
    tx_drain_one(1'b0, 8'h00);
    rx_pop_one();

    // RX simultaneous push+pop at a level of 6: ENDPOINT_BUSY must stay low
    for (int i = 0; i < 6; i++) rx_send(8'($urandom), 0);
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom);
      check("rx_sim_head", bus.RX_DATA, rx_model[0]);
      bus.DATA_BYTE_READY = 1'b1;
      bus.RX_BYTE = b;
      bus.RX_POP = 1'b1;
      tick();
      bus.RX_POP = 1'b0;
      bus.DATA_BYTE_READY = 1'b0;
      void'(rx_model.pop_front());
      rx_model.push_back(b);
      check("rx_sim_rsb", bus.RSB_INT_EN, 1);
      tick();
      check("rx_sim_ep_busy", bus.ENDPOINT_BUSY, 0);
      check("rx_sim_valid", bus.RX_VALID, 1);
    end
    for (int i = 0; i < 6; i++) rx_pop_one();
    check("rx_sim_empty", bus.RX_VALID, 0);

    // TX simultaneous push+pop at a level of 7: TX_FULL must stay low
    bus.FT_245_SM_BUSY = 1'b1;
    for (int i = 0; i < 7; i++) tx_push(8'($urandom));
    bus.FT_245_SM_BUSY = 1'b0;
    for (int i = 0; i < 20; i++) tx_drain_one(1'b1, 8'($urandom));
    for (int i = 0; i < 7; i++) tx_drain_one(1'b0, 8'h00);

    // Reset while TX is requesting and RX is acknowledging
    bus.FT_245_SM_BUSY = 1'b1;
    tx_push(8'($urandom));
    tx_push(8'($urandom));
    rx_send(8'($urandom), 0);
    bus.FT_245_SM_BUSY = 1'b0;
    wait_wen(ok);
    bus.DATA_BYTE_READY = 1'b1;
    bus.RX_BYTE = 8'($urandom);
    tick();
    check("pre_rst_wen", bus.WRITE_EN, 1);
    check("pre_rst_rsb", bus.RSB_INT_EN, 1);
    check("pre_rst_ovf", bus.RX_OVERFLOW, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsb", bus.RSB_INT_EN, 0);
    check("mid_rst_ep_busy", bus.ENDPOINT_BUSY, 0);
    check("mid_rst_wen", bus.WRITE_EN, 0);
    check("mid_rst_wbyte", bus.WRITE_BYTE, 0);
    check("mid_rst_rx_valid", bus.RX_VALID, 0);
    check("mid_rst_tx_full", bus.TX_FULL, 0);
    check("mid_rst_ovf", bus.RX_OVERFLOW, 0);
    bus.DATA_BYTE_READY = 1'b0;
    rx_model.delete();
    tx_model.delete();
    ovf_model = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("post_rst_wen", bus.WRITE_EN, 0);
    check("post_rst_rx_valid", bus.RX_VALID, 0);
    rx_send(8'($urandom), 1);
    rx_pop_one();
    check("post_rst_rx_empty", bus.RX_VALID, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
